rec_order_ctrl: RTL and testbench
=================================

Name: rec_order_ctrl

Overview:
Parametrised successor to the receive unit. Queues user send orders, streams exactly ORDER_SAMPLES processed samples per order from the buffer to the PS-side AXI-stream output with ready/valid backpressure, and generates RAM write addresses that wrap at RAM_DEPTH. Sits between the processing buffer and the AXI port, enabled by the decoder.

Parameters:
DATA_W, 25, sample width on buf_in/axi_data
ORDER_SAMPLES, 50, samples transferred per order (>=1)
MAX_ORDERS, 5, max queued orders (>=1)
RAM_DEPTH, 100, RAM entries; ram_addr wraps RAM_DEPTH-1 -> 0
ADDR_W, 7, ram_addr width; requires RAM_DEPTH <= 2**ADDR_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
rec_en  in  1  decoder enable
on  in  1  system on
off  in  1  system off (dominates on)
order_come  in  1  one-cycle order request
valid  in  1  buf_in holds a valid sample
buf_in  in  DATA_W  sample from buffer
axi_ready  in  1  PS sink ready
send_en  out  1  buffer send enable
axi_data  out  DATA_W  registered sample to PS
axi_valid  out  1  axi_data valid
axi_last  out  1  final sample of current order
ram_addr  out  ADDR_W  RAM write address of captured sample
ram_we  out  1  RAM write strobe, one per captured sample
order_full  out  1  order_count == MAX_ORDERS
no_order  out  1  order_count == 0
sending  out  1  transfer in progress
order_done  out  1  one-cycle pulse at order completion
order_rej  out  1  one-cycle pulse, order dropped while full
order_count  out  $clog2(MAX_ORDERS+1)  queued orders incl. active
rej_cnt  out  8  rejected-order count (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at clk edge): all registers 0, state IDLE; outputs 0 except no_order=1.
- gate = rec_en & on & !off.
- Order queue, per cycle: accept = order_come & (!order_full | order_done).
  - accept & !order_done: +1.
  - accept & order_done: unchanged.
  - order_done & !accept: -1.
  - order_come & !accept: order_rej=1, count unchanged.
- FSM:
  - IDLE: order_count>0 & gate -> XFER.
  - XFER: capture = valid & gate & (!axi_valid | axi_ready). On capture:
    - axi_data<=buf_in, axi_valid<=1, ram_we=1 with ram_addr = current address, then ram_addr increments with wrap.
    - sample_cnt++; axi_last<=1 on the ORDER_SAMPLES-th capture, with sample_cnt->0 and state->DONE.
  - DONE: no capture; when axi_valid=0 or axi_ready=1, order_done=1 for 1 cycle -> IDLE.
- axi_valid clears on axi_ready & !capture; axi_data and axi_last hold while axi_valid & !axi_ready.
- axi_last clears with the beat's handshake.
- Latency buf_in -> axi_data: 1 cycle.
- send_en = (state==XFER) & gate; sending = state in {XFER, DONE}.
- gate drop mid-order: capture stalls, sample_cnt and ram_addr hold; pending beat still drains on axi_ready; resume on gate return.
- ram_addr is not cleared between orders, only by reset.
- Reset mid-order: aborts the transfer; queued orders are lost.

Optional Feature:
- REC_REJ_CNT_EN defined: rej_cnt increments on each order_rej, saturates at 255, cleared only by reset.
- Undefined: rej_cnt tied to 0, no counter logic.

Test Plan:
- Reset, then one order_come, gate=1, valid=1, axi_ready=1 -> 50 beats.
  - ram_addr 0..49.
  - axi_last on beat 50 only.
  - order_done one cycle after the last beat; order_count 1->0; no_order=1.
- 6 order_come pulses, no gate -> order_count=5, order_full=1, one order_rej.
  - With REC_REJ_CNT_EN: rej_cnt=1.
- order_come coincident with order_done while full -> order_count stays 5, no order_rej.
- axi_ready=0 for 3 cycles mid-order -> axi_data/axi_valid held; no capture; sample total still exactly 50.
- off=1 for 10 cycles at sample 20 -> send_en=0, ram_addr frozen at 20; resumes at 20 when off=0.
- Two back-to-back orders, RAM_DEPTH=100 -> ram_addr 0..99, wraps to 0 on sample 101 (order 3 start).

Source files
------------

// File: rtl/rec_order_ctrl_if.sv
// -----------------------------------------------------------------------------
// rec_order_ctrl_if
// Groups the buffer-side and PS-side streaming signals of rec_order_ctrl.
//
// Signals
//   valid      buffer -> ctrl   buf_in holds a valid sample
//   buf_in     buffer -> ctrl   sample from the processing buffer
//   send_en    ctrl -> buffer   buffer send enable
//   axi_data   ctrl -> PS       registered sample
//   axi_valid  ctrl -> PS       axi_data valid
//   axi_last   ctrl -> PS       final sample of the current order
//   axi_ready  PS -> ctrl       PS sink ready
//   ram_addr   ctrl -> RAM      write address of the captured sample
//   ram_we     ctrl -> RAM      write strobe, one per captured sample
//
// Modports
//   master : the controller side
//   slave  : the environment side (buffer, PS sink, RAM)
// -----------------------------------------------------------------------------
interface rec_order_ctrl_if #(
    parameter int DATA_W = 25,
    parameter int ADDR_W = 7
);
    logic              valid;
    logic [DATA_W-1:0] buf_in;
    logic              send_en;
    logic [DATA_W-1:0] axi_data;
    logic              axi_valid;
    logic              axi_last;
    logic              axi_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;

    modport master (
        input  valid, buf_in, axi_ready,
        output send_en, axi_data, axi_valid, axi_last, ram_addr, ram_we
    );

    modport slave (
        output valid, buf_in, axi_ready,
        input  send_en, axi_data, axi_valid, axi_last, ram_addr, ram_we
    );
endinterface

// File: rtl/rec_order_ctrl.sv
// -----------------------------------------------------------------------------
// rec_order_ctrl
// Queues user send orders and streams exactly ORDER_SAMPLES samples per order
// from the processing buffer to the PS-side AXI-stream output with ready/valid
// backpressure. Every captured sample is also given a RAM write address that
// wraps at RAM_DEPTH and is only cleared by reset.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   rec_en_i       decoder enable
//   on_i / off_i   system on / off (off dominates)
//   order_come_i   one-cycle order request
//   bus            rec_order_ctrl_if.master (buffer, AXI-stream and RAM signals)
//   order_full_o   order_count == MAX_ORDERS
//   no_order_o     order_count == 0
//   sending_o      transfer in progress (XFER or DONE)
//   order_done_o   one-cycle pulse when an order completes
//   order_rej_o    one-cycle pulse when a request is dropped while full
//   order_count_o  queued orders including the active one
//   rej_cnt_o      rejected-order count
//
// Build option
//   REC_REJ_CNT_EN  when defined, rej_cnt_o counts rejections (saturating at
//                   255, cleared only by reset); otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module rec_order_ctrl #(
    parameter int DATA_W        = 25,
    parameter int ORDER_SAMPLES = 50,
    parameter int MAX_ORDERS    = 5,
    parameter int RAM_DEPTH     = 100,
    parameter int ADDR_W        = 7
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                rec_en_i,
    input  logic                                on_i,
    input  logic                                off_i,
    input  logic                                order_come_i,
    rec_order_ctrl_if.master                    bus,
    output logic                                order_full_o,
    output logic                                no_order_o,
    output logic                                sending_o,
    output logic                                order_done_o,
    output logic                                order_rej_o,
    output logic [$clog2(MAX_ORDERS+1)-1:0]     order_count_o,
    output logic [7:0]                          rej_cnt_o
);

    localparam int CNT_W  = $clog2(MAX_ORDERS + 1);
    localparam int SCNT_W = $clog2(ORDER_SAMPLES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic [CNT_W-1:0]  count_q,      count_d;
    logic [SCNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] axi_data_q,   axi_data_d;
    logic              axi_valid_q,  axi_valid_d;
    logic              axi_last_q,   axi_last_d;

    logic gate_s;
    logic capture_s;
    logic last_sample_s;
    logic order_done_s;
    logic full_s;
    logic accept_s;
    logic rej_s;

    assign gate_s        = rec_en_i & on_i & ~off_i;
    // A new sample may only be taken when the output register is free or is
    // being emptied by the sink in this same cycle.
    assign capture_s     = (state_q == ST_XFER) & bus.valid & gate_s
                         & (~axi_valid_q | bus.axi_ready);
    assign last_sample_s = (sample_cnt_q == SCNT_W'(ORDER_SAMPLES - 1));
    // Completion waits until the final beat has left (or is leaving) the port.
    assign order_done_s  = (state_q == ST_DONE) & (~axi_valid_q | bus.axi_ready);
    assign full_s        = (count_q == CNT_W'(MAX_ORDERS));
    // A completing order frees a slot in the same cycle, so a full queue can
    // still take a request that coincides with order_done.
    assign accept_s      = order_come_i & (~full_s | order_done_s);
    assign rej_s         = order_come_i & ~accept_s;

    // Next-state logic for the order queue, FSM, sample counter, address and output beat.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        sample_cnt_d = sample_cnt_q;
        addr_d       = addr_q;
        axi_data_d   = axi_data_q;
        axi_valid_d  = axi_valid_q;
        axi_last_d   = axi_last_q;

        if (accept_s && !order_done_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (order_done_s && !accept_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end

        case (state_q)
            ST_IDLE: begin
                if ((count_q != CNT_W'(0)) && gate_s) begin
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (capture_s) begin
                    if (last_sample_s) begin
                        sample_cnt_d = SCNT_W'(0);
                        state_d      = ST_DONE;
                    end else begin
                        sample_cnt_d = sample_cnt_q + SCNT_W'(1);
                    end
                end else begin
                    sample_cnt_d = sample_cnt_q;
                end
            end
            ST_DONE: begin
                if (order_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture_s) begin
            axi_data_d  = bus.buf_in;
            axi_valid_d = 1'b1;
            axi_last_d  = last_sample_s;
            if (addr_q == ADDR_W'(RAM_DEPTH - 1)) begin
                addr_d = ADDR_W'(0);
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end else if (bus.axi_ready) begin
            axi_valid_d = 1'b0;
            axi_last_d  = 1'b0;
        end else begin
            axi_valid_d = axi_valid_q;
            axi_last_d  = axi_last_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            sample_cnt_q <= '0;
            addr_q       <= '0;
            axi_data_q   <= '0;
            axi_valid_q  <= 1'b0;
            axi_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            sample_cnt_q <= sample_cnt_d;
            addr_q       <= addr_d;
            axi_data_q   <= axi_data_d;
            axi_valid_q  <= axi_valid_d;
            axi_last_q   <= axi_last_d;
        end
    end

`ifdef REC_REJ_CNT_EN
    logic [7:0] rej_cnt_q;

    // Saturating count of dropped order requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rej_cnt_q <= 8'd0;
        end else if (rej_s && (rej_cnt_q != 8'hFF)) begin
            rej_cnt_q <= rej_cnt_q + 8'd1;
        end else begin
            rej_cnt_q <= rej_cnt_q;
        end
    end

    assign rej_cnt_o = rej_cnt_q;
`else
    assign rej_cnt_o = 8'd0;
`endif

    assign bus.send_en   = (state_q == ST_XFER) & gate_s;
    assign bus.axi_data  = axi_data_q;
    assign bus.axi_valid = axi_valid_q;
    assign bus.axi_last  = axi_last_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_we    = capture_s;

    assign order_full_o  = full_s;
    assign no_order_o    = (count_q == CNT_W'(0));
    assign sending_o     = (state_q == ST_XFER) | (state_q == ST_DONE);
    assign order_done_o  = order_done_s;
    assign order_rej_o   = rej_s;
    assign order_count_o = count_q;

endmodule

// File: tb/tb_rec_order_ctrl.sv
module tb_rec_order_ctrl;

    localparam int DATA_W        = 25;
    localparam int ORDER_SAMPLES = 50;
    localparam int MAX_ORDERS    = 5;
    localparam int RAM_DEPTH     = 100;
    localparam int ADDR_W        = 7;
    localparam int CNT_W         = $clog2(MAX_ORDERS + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rec_en;
    logic             on;
    logic             off;
    logic             order_come;
    logic             order_full;
    logic             no_order;
    logic             sending;
    logic             order_done;
    logic             order_rej;
    logic [CNT_W-1:0] order_count;
    logic [7:0]       rej_cnt;

    rec_order_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

    rec_order_ctrl #(
        .DATA_W(DATA_W), .ORDER_SAMPLES(ORDER_SAMPLES), .MAX_ORDERS(MAX_ORDERS),
        .RAM_DEPTH(RAM_DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rec_en_i(rec_en), .on_i(on), .off_i(off),
        .order_come_i(order_come), .bus(bif),
        .order_full_o(order_full), .no_order_o(no_order), .sending_o(sending),
        .order_done_o(order_done), .order_rej_o(order_rej),
        .order_count_o(order_count), .rej_cnt_o(rej_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit                mon_en = 1'b0;
    int                m_cnt = 0;
    int                m_accepted = 0;
    int                m_dones = 0;
    int                m_rej_cnt = 0;
    int                dut_rej_seen = 0;
    int                beats = 0;
    int                caps = 0;
    int                exp_addr = 0;
    logic [DATA_W:0]   exp_q[$];
    bit                hold_pend = 1'b0;
    logic [DATA_W-1:0] hold_data;
    logic              hold_last;
    bit                coincided = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic            gate;
        logic            acc;
        logic            rej;
        logic [DATA_W:0] e;
        if (mon_en) begin
            gate = rec_en & on & ~off;

            chk("order_count", 32'(order_count), 32'(m_cnt));
            chk("no_order", 32'(no_order), 32'(m_cnt == 0));
            chk("order_full", 32'(order_full), 32'(m_cnt == MAX_ORDERS));
            chk("rej_cnt", 32'(rej_cnt), 32'(m_rej_cnt));
            if (!gate) chk("send_en_gated", 32'(bif.send_en), 32'd0);

            // a stalled beat must stay put
            if (hold_pend) begin
                chk("hold_valid", 32'(bif.axi_valid), 32'd1);
                chk("hold_data", 32'(bif.axi_data), 32'(hold_data));
                chk("hold_last", 32'(bif.axi_last), 32'(hold_last));
            end
            hold_pend = bif.axi_valid & ~bif.axi_ready;
            hold_data = bif.axi_data;
            hold_last = bif.axi_last;

            // beat leaving the port
            if (bif.axi_valid && bif.axi_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected actual=%0h required=none", bif.axi_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(bif.axi_data), 32'(e[DATA_W-1:0]));
                    chk("beat_last", 32'(bif.axi_last), 32'(e[DATA_W]));
                end
                beats++;
            end

            // completion only once all beats of the order have left
            if (order_done) begin
                m_dones++;
                chk("done_beats", 32'(beats), 32'(m_dones * ORDER_SAMPLES));
            end

            // captured sample: legal, in budget, next RAM address
            if (bif.ram_we) begin
                chk("capture_legal", 32'(bif.valid & gate & (~bif.axi_valid | bif.axi_ready)), 32'd1);
                chk("capture_budget", 32'(caps < m_accepted * ORDER_SAMPLES), 32'd1);
                chk("send_en_on_we", 32'(bif.send_en), 32'd1);
                chk("ram_addr", 32'(bif.ram_addr), 32'(exp_addr));
                exp_addr = (exp_addr + 1) % RAM_DEPTH;
                exp_q.push_back({(caps % ORDER_SAMPLES) == ORDER_SAMPLES - 1, bif.buf_in});
                caps++;
            end

            // order queue rules
            acc = order_come & ((m_cnt < MAX_ORDERS) | order_done);
            rej = order_come & ~acc;
            chk("order_rej", 32'(order_rej), 32'(rej));
            if (order_rej) dut_rej_seen++;
            if (acc) m_accepted++;
`ifdef REC_REJ_CNT_EN
            if (rej && m_rej_cnt < 255) m_rej_cnt++;
`endif
            m_cnt = m_cnt + int'(acc) - int'(order_done);
        end
    end

    initial begin
        bit drained;
        rst_n         = 1'b0;
        rec_en        = 1'b0;
        on            = 1'b0;
        off           = 1'b0;
        order_come    = 1'b0;
        bif.valid     = 1'b0;
        bif.buf_in    = '0;
        bif.axi_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_axi_valid", 32'(bif.axi_valid), 32'd0);
        chk("rst_axi_last", 32'(bif.axi_last), 32'd0);
        chk("rst_axi_data", 32'(bif.axi_data), 32'd0);
        chk("rst_send_en", 32'(bif.send_en), 32'd0);
        chk("rst_ram_we", 32'(bif.ram_we), 32'd0);
        chk("rst_ram_addr", 32'(bif.ram_addr), 32'd0);
        chk("rst_order_count", 32'(order_count), 32'd0);
        chk("rst_no_order", 32'(no_order), 32'd1);
        chk("rst_order_full", 32'(order_full), 32'd0);
        chk("rst_sending", 32'(sending), 32'd0);
        chk("rst_order_done", 32'(order_done), 32'd0);
        chk("rst_order_rej", 32'(order_rej), 32'd0);
        chk("rst_rej_cnt", 32'(rej_cnt), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        on     = 1'b1;

        // six requests with the decoder disabled: five queue, one dropped
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 order_come = 1'b1;
            @(posedge clk); #1 order_come = 1'b0;
        end
        @(posedge clk); #1;
        chk("fill_count", 32'(order_count), 32'd5);
        chk("fill_full", 32'(order_full), 32'd1);
        chk("fill_rej_pulses", 32'(dut_rej_seen), 32'd1);
`ifdef REC_REJ_CNT_EN
        chk("fill_rej_cnt", 32'(rej_cnt), 32'd1);
`else
        chk("fill_rej_cnt", 32'(rej_cnt), 32'd0);
`endif

        // randomized run with a ready stall, an off window and an on drop
        rec_en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            bif.valid     = ($urandom_range(0, 9) < 7);
            bif.buf_in    = DATA_W'($urandom);
            bif.axi_ready = (cyc >= 400 && cyc < 403) ? 1'b0 : ($urandom_range(0, 9) < 8);
            off           = (cyc >= 800 && cyc < 810) || ($urandom_range(0, 99) == 0);
            on            = !(cyc >= 1500 && cyc < 1520);
            order_come    = ($urandom_range(0, 59) == 0);
            #1;
            if (!coincided && order_done && order_count == CNT_W'(MAX_ORDERS)) begin
                order_come = 1'b1;
                coincided  = 1'b1;
            end
        end
        chk("coincide_seen", 32'(coincided), 32'd1);

        // drain everything still queued
        @(posedge clk);
        #1;
        order_come    = 1'b0;
        on            = 1'b1;
        off           = 1'b0;
        bif.valid     = 1'b1;
        bif.axi_ready = 1'b1;
        drained       = 1'b0;
        for (int cyc = 0; cyc < 4000 && !drained; cyc++) begin
            @(posedge clk);
            #1;
            bif.buf_in = DATA_W'($urandom);
            drained    = no_order && !sending && !bif.axi_valid;
        end
        chk("drain_done", 32'(drained), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("dones_total", 32'(m_dones), 32'(m_accepted));
        chk("beats_total", 32'(beats), 32'(m_accepted * ORDER_SAMPLES));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("final_count", 32'(order_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
